decode_stage_hz: RTL and testbench

//  Parametrised ID stage plus ID/EX pipeline register for the 5-stage RISC-V core.

---
 rtl/decode_stage_hz.sv | 248 ++++++++++++++++++++++++
 tb/tb_decode_stage_hz.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// ID stage and ID/EX register: decode, register file with write-through
// bypass, load-use stall detection, hold/flush control and a valid bit.
// Ports:
//   clk, rst (async, active-low)
//   ID in : InstrD, PCD, PCPlus4D, ValidD
//   WB in : RegWriteW, RDW, ResultW
//   ctl in: HoldE, FlushE
//   out   : StallD (comb), ValidE plus the registered E-stage bundle
module decode_stage_hz #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ALUCTL_W = 3,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         InstrD,
  input  logic [XLEN-1:0]     PCD,
  input  logic [XLEN-1:0]     PCPlus4D,
  input  logic                ValidD,
  input  logic                RegWriteW,
  input  logic [AW-1:0]       RDW,
  input  logic [XLEN-1:0]     ResultW,
  input  logic                HoldE,
  input  logic                FlushE,
  output logic                StallD,
  output logic                ValidE,
  output logic                RegWriteE,
  output logic                ALUSrcE,
  output logic                MemWriteE,
  output logic                ResultSrcE,
  output logic                BranchE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [XLEN-1:0]     RD1_E,
  output logic [XLEN-1:0]     RD2_E,
  output logic [XLEN-1:0]     Imm_Ext_E,
  output logic [XLEN-1:0]     PCE,
  output logic [XLEN-1:0]     PCPlus4E,
  output logic [AW-1:0]       RS1_E,
  output logic [AW-1:0]       RS2_E,
  output logic [AW-1:0]       RD_E
);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                alu_src;
    logic                mem_write;
    logic                result_src;
    logic                branch;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc4;
    logic [AW-1:0]       rs1;
    logic [AW-1:0]       rs2;
    logic [AW-1:0]       rd;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic            f7b5;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            is_lw;
  logic            is_sw;
  logic            is_r;
  logic            is_i;
  logic            is_b;
  logic            c_rw;
  logic            c_asrc;
  logic            c_mw;
  logic            c_rsrc;
  logic            c_br;
  logic [2:0]      c_alu;
  logic [2:0]      alu_f3;
  logic            uses_rs2;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wb_en;
  logic            hz_rs1;
  logic            hz_rs2;

  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign f7b5 = InstrD[30];
  assign rs1  = InstrD[15 +: AW];
  assign rs2  = InstrD[20 +: AW];
  assign rd   = InstrD[7 +: AW];

  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_I);
  assign is_b  = (op == OP_B);

  assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                  InstrD[30:25], InstrD[11:8], 1'b0};

  // Shared by R and I-ALU; only R-type can select sub.
  always_comb begin
    alu_f3 = 3'b000;
    unique case (f3)
      3'b000:  alu_f3 = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_f3 = 3'b101;
      3'b110:  alu_f3 = 3'b011;
      3'b111:  alu_f3 = 3'b010;
      default: alu_f3 = 3'b000;
    endcase
  end

  always_comb begin
    c_rw     = 1'b0;
    c_asrc   = 1'b0;
    c_mw     = 1'b0;
    c_rsrc   = 1'b0;
    c_br     = 1'b0;
    c_alu    = 3'b000;
    uses_rs2 = 1'b0;
    imm32    = '0;
    unique case (1'b1)
      is_lw: begin
        c_rw   = 1'b1;
        c_asrc = 1'b1;
        c_rsrc = 1'b1;
        imm32  = imm_i;
      end
      is_sw: begin
        c_asrc   = 1'b1;
        c_mw     = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = imm_s;
      end
      is_r: begin
        c_rw     = 1'b1;
        c_alu    = alu_f3;
        uses_rs2 = 1'b1;
      end
      is_i: begin
        c_rw   = 1'b1;
        c_asrc = 1'b1;
        c_alu  = alu_f3;
        imm32  = imm_i;
      end
      is_b: begin
        c_br     = 1'b1;
        c_alu    = 3'b001;
        uses_rs2 = 1'b1;
        imm32    = imm_b;
      end
      default: ;
    endcase
  end

  // rf[0] is never written, so x0 reads zero without a special case.
  assign wb_en = RegWriteW && (RDW != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[RDW] <= ResultW;
    end
  end

  // Same-cycle writeback is forwarded so ID never sees stale data.
  always_comb begin
    rd1 = rf[rs1];
    rd2 = rf[rs2];
    if (wb_en && (RDW == rs1)) rd1 = ResultW;
    if (wb_en && (RDW == rs2)) rd2 = ResultW;
  end

  assign hz_rs1 = (q.rd == rs1);
  assign hz_rs2 = uses_rs2 && (q.rd == rs2);
  assign StallD = q.valid && q.result_src && (q.rd != '0)
               && ValidD && (hz_rs1 || hz_rs2);

  always_comb begin
    d       = '0;
    d.valid = ValidD;
    if (ValidD) begin
      d.reg_write  = c_rw;
      d.alu_src    = c_asrc;
      d.mem_write  = c_mw;
      d.result_src = c_rsrc;
      d.branch     = c_br;
      d.alu_ctl    = ALUCTL_W'(c_alu);
    end
    d.rd1 = rd1;
    d.rd2 = rd2;
    d.imm = XLEN'($signed(imm32));
    d.pc  = PCD;
    d.pc4 = PCPlus4D;
    d.rs1 = rs1;
    d.rs2 = rs2;
    d.rd  = rd;
  end

  // Flush beats hold; a load-use stall only bubbles when not held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (FlushE || (!HoldE && StallD)) begin
      q <= '0;
    end else if (!HoldE) begin
      q <= d;
    end
  end

  assign ValidE      = q.valid;
  assign RegWriteE   = q.reg_write;
  assign ALUSrcE     = q.alu_src;
  assign MemWriteE   = q.mem_write;
  assign ResultSrcE  = q.result_src;
  assign BranchE     = q.branch;
  assign ALUControlE = q.alu_ctl;
  assign RD1_E       = q.rd1;
  assign RD2_E       = q.rd2;
  assign Imm_Ext_E   = q.imm;
  assign PCE         = q.pc;
  assign PCPlus4E    = q.pc4;
  assign RS1_E       = q.rs1;
  assign RS2_E       = q.rs2;
  assign RD_E        = q.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed cases plus random traffic
// checked every cycle against a behavioural model of the stage.
module tb_decode_stage_hz;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        HoldE;
  logic        FlushE;
  logic        StallD;
  logic        ValidE;
  logic        RegWriteE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .RegWriteW(RegWriteW),
    .RDW(RDW), .ResultW(ResultW), .HoldE(HoldE), .FlushE(FlushE),
    .StallD(StallD), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
    .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v, rw, asrc, mw, rsrc, br;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        care;
  } st_t;

  typedef struct packed {
    logic        rw, asrc, mw, rsrc, br, u2, care;
    logic [2:0]  alu;
    logic [31:0] imm;
  } dec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  st_t         e;
  st_t         nxt;
  st_t         bub;
  logic        exp_stall;
  logic [31:0] regs [32];
  logic        wen_p;
  logic [4:0]  wa_p;
  logic [31:0] wd_p;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7,
      input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                        input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d = '0;
    d.care = 1'b1;
    case (i[6:0])
      OP_LW: begin
        d.rw = 1'b1; d.asrc = 1'b1; d.rsrc = 1'b1;
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      OP_SW: begin
        d.mw = 1'b1; d.asrc = 1'b1; d.u2 = 1'b1;
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      OP_R: begin
        d.rw = 1'b1; d.u2 = 1'b1; d.care = 1'b0;
        d.alu = alu_of(i[14:12], i[30]);
      end
      OP_I: begin
        d.rw = 1'b1; d.asrc = 1'b1;
        d.alu = alu_of(i[14:12], 1'b0);
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      OP_B: begin
        d.br = 1'b1; d.u2 = 1'b1; d.alu = 3'b001;
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      default: d.care = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rdval(input logic [4:0] a,
      input logic rw, input logic [4:0] rdw, input logic [31:0] res);
    if (a == 5'd0) return 32'd0;
    if (rw && rdw == a) return res;
    return regs[a];
  endfunction

  task automatic drive(input logic [31:0] ins, input logic vd,
      input logic rw, input logic [4:0] rdw, input logic [31:0] res,
      input logic hold, input logic flush);
    dec_t        dc;
    st_t         ld;
    logic [31:0] pc;
    pc = $urandom() & 32'hFFFF_FFFC;
    InstrD = ins; ValidD = vd; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = rw; RDW = rdw; ResultW = res;
    HoldE = hold; FlushE = flush;
    dc = decode(ins);
    exp_stall = rst && e.v && e.rsrc && (e.rd != 5'd0) && vd
             && (e.rd == ins[19:15] || (dc.u2 && e.rd == ins[24:20]));
    ld = '0;
    ld.v = vd;
    if (vd) begin
      ld.rw = dc.rw; ld.asrc = dc.asrc; ld.mw = dc.mw;
      ld.rsrc = dc.rsrc; ld.br = dc.br; ld.alu = dc.alu;
    end
    ld.rd1 = rdval(ins[19:15], rw, rdw, res);
    ld.rd2 = rdval(ins[24:20], rw, rdw, res);
    ld.imm = dc.imm; ld.care = dc.care;
    ld.pc = pc; ld.pc4 = pc + 32'd4;
    ld.rs1 = ins[19:15]; ld.rs2 = ins[24:20]; ld.rd = ins[11:7];
    if (!rst || flush || (!hold && exp_stall)) nxt = bub;
    else if (hold) nxt = e;
    else nxt = ld;
    wen_p = rst && rw && (rdw != 5'd0);
    wa_p = rdw;
    wd_p = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e = nxt;
    if (wen_p) regs[wa_p] = wd_p;
  endtask

  task automatic step(input logic [31:0] ins, input logic vd,
      input logic rw, input logic [4:0] rdw, input logic [31:0] res,
      input logic hold, input logic flush);
    drive(ins, vd, rw, rdw, res, hold, flush);
    tick();
  endtask

  task automatic model_reset();
    e = bub; nxt = bub; exp_stall = 1'b0; wen_p = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 5))
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_R;
      3: op = OP_I;
      4: op = OP_B;
      default: op = 7'($urandom());
    endcase
    return enc(7'($urandom()), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 3'($urandom()),
               5'($urandom_range(0, 7)), op);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("StallD", 64'(StallD), 64'(exp_stall));
      chk("ValidE", 64'(ValidE), 64'(e.v));
      chk("RegWriteE", 64'(RegWriteE), 64'(e.rw));
      chk("ALUSrcE", 64'(ALUSrcE), 64'(e.asrc));
      chk("MemWriteE", 64'(MemWriteE), 64'(e.mw));
      chk("ResultSrcE", 64'(ResultSrcE), 64'(e.rsrc));
      chk("BranchE", 64'(BranchE), 64'(e.br));
      chk("ALUControlE", 64'(ALUControlE), 64'(e.alu));
      chk("RD1_E", 64'(RD1_E), 64'(e.rd1));
      chk("RD2_E", 64'(RD2_E), 64'(e.rd2));
      if (e.care) chk("Imm_Ext_E", 64'(Imm_Ext_E), 64'(e.imm));
      chk("PCE", 64'(PCE), 64'(e.pc));
      chk("PCPlus4E", 64'(PCPlus4E), 64'(e.pc4));
      chk("RS1_E", 64'(RS1_E), 64'(e.rs1));
      chk("RS2_E", 64'(RS2_E), 64'(e.rs2));
      chk("RD_E", 64'(RD_E), 64'(e.rd));
    end
  end

  initial begin
    logic [31:0] add3;
    logic [31:0] add6;
    logic [31:0] beq;
    bub = '0;
    bub.care = 1'b1;
    rst = 1'b0;
    InstrD = '0; PCD = '0; PCPlus4D = '0; ValidD = 1'b0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    HoldE = 1'b0; FlushE = 1'b0;
    model_reset();
    #2;
    chk("rst_ValidE", 64'(ValidE), 64'd0);
    chk("rst_StallD", 64'(StallD), 64'd0);
    chk("rst_RD1_E", 64'(RD1_E), 64'd0);
    chk("rst_PCE", 64'(PCE), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_on = 1'b1;

    // T1
    step(32'd0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b1, 5'd2, 32'd7, 1'b0, 1'b0);
    add3 = enc(7'd0, 5'd2, 5'd1, 3'b000, 5'd3, OP_R);
    step(add3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("T1_RD1_E", 64'(RD1_E), 64'd5);
    chk("T1_RD2_E", 64'(RD2_E), 64'd7);
    chk("T1_RegWriteE", 64'(RegWriteE), 64'd1);
    chk("T1_ALUControlE", 64'(ALUControlE), 64'd0);
    chk("T1_RD_E", 64'(RD_E), 64'd3);
    chk("T1_ValidE", 64'(ValidE), 64'd1);

    // T2
    step(enc(7'd0, 5'd8, 5'd1, 3'b010, 5'd5, OP_LW),
         1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("T2_lw_ResultSrcE", 64'(ResultSrcE), 64'd1);
    chk("T2_lw_Imm", 64'(Imm_Ext_E), 64'd8);
    add6 = enc(7'd0, 5'd2, 5'd5, 3'b000, 5'd6, OP_R);
    drive(add6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("T2_StallD", 64'(StallD), 64'd1);
    tick();
    chk("T2_bub_ValidE", 64'(ValidE), 64'd0);
    chk("T2_bub_RegWriteE", 64'(RegWriteE), 64'd0);
    drive(add6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("T2_nostall", 64'(StallD), 64'd0);
    tick();
    chk("T2_add_ValidE", 64'(ValidE), 64'd1);
    chk("T2_add_RD_E", 64'(RD_E), 64'd6);

    // T3
    step(enc(7'd0, 5'd0, 5'd4, 3'b000, 5'd7, OP_I),
         1'b1, 1'b1, 5'd4, 32'hDEAD, 1'b0, 1'b0);
    chk("T3_bypass", 64'(RD1_E), 64'hDEAD);
    step(enc(7'd0, 5'd0, 5'd0, 3'b000, 5'd7, OP_I),
         1'b1, 1'b1, 5'd0, 32'hBEEF, 1'b0, 1'b0);
    chk("T3_x0", 64'(RD1_E), 64'd0);

    // T4: beq x1,x2,-4
    beq = enc(7'h7f, 5'd2, 5'd1, 3'b000, 5'b11101, OP_B);
    step(beq, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("T4_Imm", 64'(Imm_Ext_E), 64'hFFFF_FFFC);
    chk("T4_BranchE", 64'(BranchE), 64'd1);
    chk("T4_ALUControlE", 64'(ALUControlE), 64'd1);
    step(beq, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("T4_flush_ValidE", 64'(ValidE), 64'd0);
    chk("T4_flush_BranchE", 64'(BranchE), 64'd0);

    // T5: or x8,x1,x2 then held
    step(enc(7'd0, 5'd2, 5'd1, 3'b110, 5'd8, OP_R),
         1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(rand_instr(), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      chk("T5_hold_RD1_E", 64'(RD1_E), 64'd5);
      chk("T5_hold_RD2_E", 64'(RD2_E), 64'd7);
      chk("T5_hold_ALU", 64'(ALUControlE), 64'd3);
      chk("T5_hold_RD_E", 64'(RD_E), 64'd8);
    end
    step(rand_instr(), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    chk("T5_holdflush_ValidE", 64'(ValidE), 64'd0);
    chk("T5_holdflush_RD1_E", 64'(RD1_E), 64'd0);

    // T6: async reset mid-cycle
    step(add3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("T6_pre_ValidE", 64'(ValidE), 64'd1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("T6_ValidE", 64'(ValidE), 64'd0);
    chk("T6_RegWriteE", 64'(RegWriteE), 64'd0);
    chk("T6_RD1_E", 64'(RD1_E), 64'd0);
    chk("T6_PCE", 64'(PCE), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(enc(7'd0, 5'd0, 5'd1, 3'b000, 5'd9, OP_I),
         1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("T6_x1_cleared", 64'(RD1_E), 64'd0);
    chk("T6_post_ValidE", 64'(ValidE), 64'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(rand_instr(), $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
           $urandom(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
